// File: rtl/multicycle_pkg.sv
// Shared opcodes, FSM states and instruction field
// positions for the multi-cycle core.
package multicycle_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_LW   = 5'b01001;
  localparam logic [4:0] OP_SW   = 5'b01010;
  localparam logic [4:0] OP_BEQ  = 5'b01100;
  localparam logic [4:0] OP_JMP  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 11;
  localparam int F_RD_HI  = 10;
  localparam int F_RD_LO  = 8;
  localparam int F_RA_HI  = 7;
  localparam int F_RA_LO  = 5;
  localparam int F_RB_HI  = 4;
  localparam int F_RB_LO  = 2;
  localparam int F_IMM_HI = 4;
  localparam int F_IMM_LO = 0;
  localparam int F_JT_HI  = 10;
  localparam int F_JT_LO  = 0;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

endpackage

// File: rtl/multicycle_regfile.sv
// 8-entry register file: two operand read ports, one
// write port and a debug read port; r0 reads as zero.
import multicycle_pkg::*;

module multicycle_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_ra1,
  input  logic [2:0]        i_ra2,
  input  logic [2:0]        i_ra3,
  input  logic              i_we,
  input  logic [2:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_rd3
);

  logic [DATA_W-1:0] r_mem [8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
    end else if (i_we && i_wa != 3'd0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 3'd0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 3'd0) ? '0 : r_mem[i_ra2];
  assign o_rd3 = (i_ra3 == 3'd0) ? '0 : r_mem[i_ra3];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXEC/
// MEM/WB FSM with req/ack instruction and data memories.
import multicycle_pkg::*;

module multicycle_core #(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              retire,
  output logic              illegal
);

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;

  logic [4:0]        w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_ra;
  logic [2:0]        w_rb;
  logic [2:0]        w_rsel;
  logic [4:0]        w_imm5;
  logic [DATA_W-1:0] w_imm_d;
  logic [PC_W-1:0]   w_imm_p;
  logic [PC_W-1:0]   w_jt;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_we;
  logic              w_is_alu;
  logic              w_is_addi;
  logic              w_is_lw;
  logic              w_is_sw;
  logic              w_is_beq;
  logic              w_is_jmp;
  logic              w_is_halt;

  assign w_op    = r_ir[F_OP_HI:F_OP_LO];
  assign w_rd    = r_ir[F_RD_HI:F_RD_LO];
  assign w_ra    = r_ir[F_RA_HI:F_RA_LO];
  assign w_rb    = r_ir[F_RB_HI:F_RB_LO];
  assign w_imm5  = r_ir[F_IMM_HI:F_IMM_LO];
  assign w_imm_d = DATA_W'($signed(w_imm5));
  assign w_imm_p = PC_W'($signed(w_imm5));
  assign w_jt    = PC_W'(r_ir[F_JT_HI:F_JT_LO]);

  assign w_is_alu  = (w_op <= OP_SLT);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_jmp  = (w_op == OP_JMP);
  assign w_is_halt = (w_op == OP_HALT);

  // SW and BEQ use rd as their second source operand
  assign w_rsel = (w_is_sw || w_is_beq) ? w_rd : w_rb;

  multicycle_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_ra),
    .i_ra2 (w_rsel),
    .i_ra3 (dbg_raddr),
    .i_we  (w_we),
    .i_wa  (w_rd),
    .i_wd  (r_res),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .o_rd3 (dbg_rdata)
  );

  always_comb begin
    w_alu = r_a + w_imm_d;
    unique case (1'b1)
      w_op == OP_ADD: w_alu = r_a + r_b;
      w_op == OP_SUB: w_alu = r_a - r_b;
      w_op == OP_AND: w_alu = r_a & r_b;
      w_op == OP_OR:  w_alu = r_a | r_b;
      w_op == OP_XOR: w_alu = r_a ^ r_b;
      w_op == OP_SLT:
        w_alu = {{(DATA_W-1){1'b0}},
                 $signed(r_a) < $signed(r_b)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BOOT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    w_we     = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    unique case (r_state)
      BOOT: w_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = DECODE;
      end
      DECODE: w_next = EXEC;
      EXEC: begin
        unique case (1'b1)
          w_is_alu || w_is_addi: w_next = WB;
          w_is_lw || w_is_sw:    w_next = MEM;
          w_is_halt: begin
            retire = 1'b1;
            w_next = HALT;
          end
          w_is_beq || w_is_jmp: begin
            retire = 1'b1;
            w_next = FETCH;
          end
          default: begin
            retire  = 1'b1;
            illegal = 1'b1;
            w_next  = FETCH;
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_sw;
        if (dmem_ack) begin
          retire = w_is_sw;
          w_next = w_is_lw ? WB : FETCH;
        end
      end
      WB: begin
        w_we   = 1'b1;
        retire = 1'b1;
        w_next = FETCH;
      end
      HALT: halted = 1'b1;
      default: w_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= PC_W'(RESET_PC);
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else begin
      if (r_state == FETCH && imem_ack) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == DECODE) begin
        r_a <= w_rd1;
        r_b <= w_rd2;
      end
      if (r_state == EXEC) begin
        r_res <= w_alu;
        // pc already points past the branch here
        if (w_is_beq && r_a == r_b) r_pc <= r_pc + w_imm_p;
        if (w_is_jmp)               r_pc <= w_jt;
      end
      if (r_state == MEM && dmem_ack && w_is_lw)
        r_res <= dmem_rdata;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_addr  = r_res;
  assign dmem_wdata = r_b;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core with latency-controlled
// instruction and data memory models.
import multicycle_pkg::*;

module tb_multicycle_core;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack;
  logic [7:0]  dmem_rdata;
  logic [2:0]  dbg_raddr;
  logic [7:0]  dbg_rdata;
  logic [7:0]  pc;
  logic        halted;
  logic        retire;
  logic        illegal;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int          i_lat;
  int          d_lat;
  int          i_cnt;
  int          d_cnt;
  int          n_cmp;
  int          n_bad;

  multicycle_core #(.DATA_W(8), .PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .pc         (pc),
    .halted     (halted),
    .retire     (retire),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (i_cnt >= i_lat);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (d_cnt >= d_lat);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (imem_req && !imem_ack) i_cnt <= i_cnt + 1;
    else                       i_cnt <= 0;
    if (dmem_req && !dmem_ack) d_cnt <= d_cnt + 1;
    else                       d_cnt <= 0;
    if (dmem_req && dmem_ack && dmem_we)
      dmem[dmem_addr] <= dmem_wdata;
  end

  function automatic logic [15:0] enc_r(
    input logic [4:0] op, input logic [2:0] rd,
    input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(
    input logic [4:0] op, input logic [2:0] rd,
    input logic [2:0] ra, input logic [4:0] imm);
    return {op, rd, ra, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 11'd0};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dbg_raddr = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_retire(input string tag);
    logic got;
    got = 1'b0;
    repeat (60) if (!got) begin
      @(negedge clk);
      got = retire;
    end
    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: retire timeout, got %b want 1", tag, got);
    end
  endtask

  task automatic test_reset();
    clear_imem();
    rst = 1'b0;
    dbg_raddr = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'd0) begin
      n_bad++; $display("FAIL reset_pc: got %h want 00", pc);
    end
    n_cmp++;
    if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_req: got %b want 000",
               {imem_req, dmem_req, dmem_we});
    end
    n_cmp++;
    if ({halted, retire, illegal} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000",
               {halted, retire, illegal});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL boot_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL first_fetch: got req=%b addr=%h want 1/00",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_alu();
    int rets;
    int cyc;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_ADDI, 3'd2, 3'd0, 5'b11101);
    imem[2] = enc_r(OP_ADD, 3'd3, 3'd1, 3'd2);
    imem[3] = enc_r(OP_SUB, 3'd4, 3'd2, 3'd1);
    imem[4] = enc_r(OP_SLT, 3'd5, 3'd2, 3'd1);
    do_reset();
    rets = 0;
    repeat (12) begin
      @(negedge clk);
      if (retire) rets++;
    end
    n_cmp++;
    if (rets !== 3 || retire !== 1'b1) begin
      n_bad++;
      $display("FAIL alu_retires: got %0d last=%b want 3/1",
               rets, retire);
    end
    dbg_raddr = 3'd3;
    @(negedge clk);
    n_cmp++;
    if (dbg_rdata !== 8'h02) begin
      n_bad++; $display("FAIL add_r3: got %h want 02", dbg_rdata);
    end
    cyc = 0;
    while (!halted && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_bad++; $display("FAIL halt: got %b want 1", halted);
    end
    dbg_raddr = 3'd2; #1;
    n_cmp++;
    if (dbg_rdata !== 8'hFD) begin
      n_bad++; $display("FAIL addi_neg: got %h want fd", dbg_rdata);
    end
    dbg_raddr = 3'd4; #1;
    n_cmp++;
    if (dbg_rdata !== 8'hF8) begin
      n_bad++; $display("FAIL sub_r4: got %h want f8", dbg_rdata);
    end
    dbg_raddr = 3'd5; #1;
    n_cmp++;
    if (dbg_rdata !== 8'h01) begin
      n_bad++; $display("FAIL slt_r5: got %h want 01", dbg_rdata);
    end
    rets = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire) rets++;
    end
    n_cmp++;
    if (rets !== 0 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_quiet: got %0d active cycles want 0", rets);
    end
  endtask

  task automatic test_mem();
    int rets;
    int cyc;
    int t_sw;
    int t_lw;
    int n_sw;
    int n_lw;
    int bad;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd5);
    imem[1] = enc_i(OP_SW, 3'd1, 3'd0, 5'd2);
    imem[2] = enc_i(OP_LW, 3'd6, 3'd0, 5'd2);
    d_lat = 3;
    do_reset();
    wait_retire("mem_addi");
    rets = 0; cyc = 0; t_sw = 0; t_lw = 0;
    n_sw = 0; n_lw = 0; bad = 0;
    while (rets < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dmem_req) begin
        if (dmem_we) n_sw++;
        else         n_lw++;
        if (dmem_addr !== 8'd2) bad++;
        if (dmem_we && dmem_wdata !== 8'd5) bad++;
      end
      if (retire) begin
        rets++;
        if (rets == 1) t_sw = cyc;
        else           t_lw = cyc;
      end
    end
    n_cmp++;
    if (n_sw !== 4 || n_lw !== 4) begin
      n_bad++;
      $display("FAIL dmem_req_len: got sw=%0d lw=%0d want 4/4",
               n_sw, n_lw);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL dmem_stable: got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (t_lw - t_sw !== 8) begin
      n_bad++;
      $display("FAIL lw_cycles: got %0d want 8", t_lw - t_sw);
    end
    n_cmp++;
    if (dmem[2] !== 8'd5) begin
      n_bad++; $display("FAIL sw_data: got %h want 05", dmem[2]);
    end
    dbg_raddr = 3'd6;
    @(negedge clk);
    n_cmp++;
    if (dbg_rdata !== 8'd5) begin
      n_bad++; $display("FAIL lw_r6: got %h want 05", dbg_rdata);
    end
    d_lat = 0;
  endtask

  task automatic test_branch();
    logic [7:0] exp_pc [5];
    clear_imem();
    imem[0]  = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd1);
    imem[1]  = {OP_JMP, 11'd9};
    imem[9]  = enc_i(OP_BEQ, 3'd1, 3'd0, 5'd5);
    imem[10] = enc_i(OP_BEQ, 3'd0, 3'd0, 5'h1F);
    exp_pc[0] = 8'd1;
    exp_pc[1] = 8'd9;
    exp_pc[2] = 8'd10;
    exp_pc[3] = 8'd10;
    exp_pc[4] = 8'd10;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_retire("branch");
      @(negedge clk);
      n_cmp++;
      if (pc !== exp_pc[k]) begin
        n_bad++;
        $display("FAIL branch_pc%0d: got %h want %h",
                 k, pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_jump_wrap();
    clear_imem();
    imem[0]   = {OP_JMP, 11'h7FF};
    imem[255] = enc_i(OP_ADDI, 3'd2, 3'd2, 5'd1);
    do_reset();
    wait_retire("jmp");
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'hFF) begin
      n_bad++; $display("FAIL jmp_trunc: got %h want ff", pc);
    end
    wait_retire("wrap");
    dbg_raddr = 3'd2;
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'h00 || dbg_rdata !== 8'h01) begin
      n_bad++;
      $display("FAIL pc_wrap: got pc=%h r2=%h want 00/01",
               pc, dbg_rdata);
    end
  endtask

  task automatic test_r0_illegal();
    int cyc;
    int ill;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd9);
    imem[1] = enc_i(OP_ADDI, 3'd0, 3'd0, 5'd7);
    imem[2] = {5'b10101, 11'h123};
    do_reset();
    wait_retire("r0_a");
    wait_retire("r0_b");
    dbg_raddr = 3'd0;
    cyc = 0; ill = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rdata !== 8'h00) begin
      n_bad++; $display("FAIL r0_zero: got %h want 00", dbg_rdata);
    end
    cyc = 1;
    if (illegal) ill++;
    while (!retire && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (illegal) ill++;
    end
    n_cmp++;
    if (cyc !== 3 || ill !== 1) begin
      n_bad++;
      $display("FAIL illegal: got cyc=%0d pulses=%0d want 3/1",
               cyc, ill);
    end
    dbg_raddr = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (pc !== 8'd3 || dbg_rdata !== 8'd9) begin
      n_bad++;
      $display("FAIL illegal_nop: got pc=%h r1=%h want 03/09",
               pc, dbg_rdata);
    end
  endtask

  task automatic test_imem_wait();
    int cyc;
    clear_imem();
    imem[0] = enc_i(OP_ADDI, 3'd1, 3'd0, 5'd3);
    i_lat = 2;
    do_reset();
    cyc = 0;
    while (!retire && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 6) begin
      n_bad++; $display("FAIL imem_wait: got %0d want 6", cyc);
    end
    i_lat = 0;
  endtask

  task automatic test_reset_mid_mem();
    int cyc;
    clear_imem();
    imem[0] = enc_i(OP_LW, 3'd1, 3'd0, 5'd0);
    d_lat = 5;
    do_reset();
    cyc = 0;
    while (!dmem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_bad++; $display("FAIL mid_mem_reach: got %b want 1", dmem_req);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || pc !== 8'd0) begin
      n_bad++;
      $display("FAIL async_rst: got dreq=%b ireq=%b pc=%h want 0/0/00",
               dmem_req, imem_req, pc);
    end
    dbg_raddr = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (dbg_rdata !== 8'd0) begin
      n_bad++; $display("FAIL rst_r1: got %h want 00", dbg_rdata);
    end
    rst = 1'b1;
    d_lat = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_lat = 0;
    d_lat = 0;
    rst = 1'b0;
    dbg_raddr = 3'd0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump_wrap();
    test_r0_illegal();
    test_imem_wait();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle 8-bit datapath. It executes one 16-bit instruction at a time through a FETCH/DECODE/EXEC/MEM/WB state machine, using a shared register file and ALU. Instruction and data memories are external and use req/ack handshakes, so variable-latency memories stall the core. Adds signed compare, jump, halt, illegal-opcode detection, a retire strobe and a debug register read port.

## Interface
- DATA_W, 8: datapath and register width (≥ 8)
- PC_W, 8: program-counter / instruction-address width
- RESET_PC, 0: PC value after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads
- dmem_rdata  in  DATA_W  load data
- dbg_raddr  in  3  debug register index
- dbg_rdata  out  DATA_W  combinational read of the register at dbg_raddr
- pc  out  PC_W  current PC
- halted  out  1  core stopped by HALT
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in EXEC for an undefined opcode

## Operation
- Fields: op[15:11], rd[10:8], ra[7:5], rb[4:2], imm5[4:0] (sign-extended to DATA_W or PC_W), jt[10:0] (truncated to PC_W).
- r0 always reads 0; writes to r0 are discarded. The register file holds 8 × DATA_W registers.
- ALU ops:
  - 00000 ADD: rd = ra + rb
  - 00001 SUB: rd = ra − rb
  - 00010 AND
  - 00011 OR
  - 00100 XOR
  - 00101 SLT: rd = (signed ra < signed rb) ? 1 : 0
- Immediate op 01000 ADDI: rd = ra + imm5.
- 01001 LW: rd = mem[ra + imm5].
- 01010 SW: mem[ra + imm5] = rd (rd is the source register).
- 01100 BEQ: if rd == ra, pc = pc + 1 + imm5.
- 01110 JMP: pc = jt.
- 11111 HALT.
- Any other opcode: the `illegal` pulse fires and the instruction retires as a NOP.
- All arithmetic wraps modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W. No flags are produced.
- States:
  - BOOT → FETCH.
  - FETCH: imem_req = 1 until imem_ack; latch IR; pc ← pc + 1. → DECODE.
  - DECODE: latch A = R[ra], B = R[rb] (or R[rd] for SW/BEQ). → EXEC.
  - EXEC: compute the ALU result or branch/jump target and update pc. ALU/ADDI → WB. LW/SW → MEM. BEQ/JMP/illegal → FETCH (retire). HALT → HALT.
  - MEM: dmem_req = 1 until dmem_ack. LW → WB with data latched. SW → FETCH (retire).
  - WB: write rd, retire → FETCH.
  - HALT: terminal until reset; halted = 1; no requests.
- Handshake rules:
  - req is a combinational function of state.
  - addr, we and wdata are stable while req is high.
  - ack in the same cycle as the first req completes the access (zero-wait).
  - ack while req is low is ignored.

## Timing
- Reset (rst low, asynchronous):
  - state = BOOT, pc = RESET_PC, all registers 0.
  - imem_req = dmem_req = dmem_we = 0.
  - halted = retire = illegal = 0.
- With zero-wait memories:
  - ALU/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/JMP/illegal: 3 cycles.
- Each cycle ack is withheld adds one cycle in FETCH or MEM.
- A register write in WB is visible on dbg_rdata on the next cycle and to the next instruction's DECODE.
- Reset asserted mid-access drops req immediately. Any outstanding ack is ignored.

## Structure
- Package `multicycle_pkg` holds:
  - opcode localparams
  - state enum (BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT)
  - instruction field bit positions
- Sub-module `multicycle_regfile`: 8 × DATA_W, two read ports, one write port, r0 hardwired to zero, third combinational debug read port.
- ALU is inline combinational logic in the core.

## Test plan
- Reset: hold rst low → pc = 0, all req low, halted = 0. Release → BOOT, then imem_req = 1 with imem_addr = 0 on the second cycle.
- Program ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2 with zero-wait imem → r3 = 0x02 on dbg, 3 retire pulses in 12 cycles. SUB r4,r2,r1 → 0xF8; SLT r5,r2,r1 → 1.
- SW r1,2(r0) then LW r6,2(r0), with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, dmem_addr = 2 stable, wdata = 5; r6 = 5. LW takes 8 cycles.
- BEQ r0,r0,−1 at pc = 10 → pc = 10 (self-loop). BEQ not taken → pc = 11. Fall-through from pc = 255 (PC_W = 8) → pc = 0. JMP jt = 0x7FF → pc = 0xFF.
- ADDI r0,r0,7 → r0 stays 0. Opcode 10101 → illegal pulse, registers unchanged, pc + 1, retire after 3 cycles.
- HALT → halted = 1 and no further req. Separately, async reset during MEM with dmem_req high → req low in the same cycle and pc = RESET_PC.
